// File: rtl/microcode_loader.sv
// Programs one 24-bit microcode word into three parallel byte-wide flash ROMs
// (JEDEC unlock/program, DQ7 polling, read-back). Define MICROCODE_LOADER_ERASE_EN for chip erase.
module microcode_loader #(
  parameter int WE_LOW   = 3,
  parameter int POLL_MAX = 1000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MICROCODE_LOADER_ERASE_EN
  input  logic        erase,
`endif
  input  logic        req,
  input  logic [18:0] addr,
  input  logic [23:0] data,
  output logic        ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        nhalt,
  output logic [18:0] fa,
  output logic [23:0] fd_o,
  output logic        fd_oe,
  input  logic [23:0] fd_i,
  output logic        nwe,
  output logic        noe
);

  typedef enum logic [2:0] {IDLE, SETUP, WLOW, HOLD, POLL, VERIFY, DONE, ERR} state_t;

  state_t      state;
  logic [2:0]  step;
  logic [7:0]  wecnt;
  logic [15:0] pollcnt;
  logic        phase;
  logic        erasing;
  logic [18:0] lat_addr;
  logic [23:0] lat_data;
  logic        start_erase;
  logic [2:0]  last_step;
  logic [42:0] next_word;
  logic        dq7_pass;

`ifdef MICROCODE_LOADER_ERASE_EN
  assign start_erase = erase;
`else
  assign start_erase = 1'b0;
`endif

  // Erase polls against an all-ones target, so the same DQ7 compare serves both modes.
  assign last_step = erasing ? 3'd5 : 3'd3;
  assign dq7_pass  = (fd_i[23] == lat_data[23]) &&
                     (fd_i[15] == lat_data[15]) &&
                     (fd_i[7]  == lat_data[7]);

  function automatic logic [42:0] bus_word(input logic [2:0]  s,
                                           input logic        er,
                                           input logic [18:0] a,
                                           input logic [23:0] d);
    logic [42:0] w;
    w = {a, d};
    if (er) begin
      case (s)
        3'd0, 3'd3: w = {19'h00555, 24'hAAAAAA};
        3'd1, 3'd4: w = {19'h002AA, 24'h555555};
        3'd2:       w = {19'h00555, 24'h808080};
        default:    w = {19'h00555, 24'h101010};
      endcase
    end else begin
      case (s)
        3'd0:    w = {19'h00555, 24'hAAAAAA};
        3'd1:    w = {19'h002AA, 24'h555555};
        3'd2:    w = {19'h00555, 24'hA0A0A0};
        default: w = {a, d};
      endcase
    end
    return w;
  endfunction

  assign next_word = bus_word(step + 3'd1, erasing, lat_addr, lat_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= 3'd0;
      wecnt    <= 8'd0;
      pollcnt  <= 16'd0;
      phase    <= 1'b0;
      erasing  <= 1'b0;
      lat_addr <= 19'h0;
      lat_data <= 24'h0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      nhalt    <= 1'b1;
      fa       <= 19'h0;
      fd_o     <= 24'h0;
      fd_oe    <= 1'b0;
      nwe      <= 1'b1;
      noe      <= 1'b1;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_erase || req) begin
            erasing  <= start_erase;
            lat_addr <= start_erase ? 19'h0 : addr;
            lat_data <= start_erase ? 24'hFFFFFF : data;
            ack      <= ~start_erase;
            busy     <= 1'b1;
            nhalt    <= 1'b0;
            error    <= 1'b0;
            step     <= 3'd0;
            pollcnt  <= 16'd0;
            fa       <= 19'h00555;
            fd_o     <= 24'hAAAAAA;
            fd_oe    <= 1'b1;
            nwe      <= 1'b1;
            noe      <= 1'b1;
            state    <= SETUP;
          end
        end

        SETUP: begin
          nwe   <= 1'b0;
          wecnt <= 8'd0;
          state <= WLOW;
        end

        WLOW: begin
          if (wecnt == 8'(WE_LOW - 1)) begin
            nwe   <= 1'b1;
            state <= HOLD;
          end else begin
            wecnt <= wecnt + 8'd1;
          end
        end

        // Address and data stay put through HOLD; the next word is loaded on leaving it.
        HOLD: begin
          if (step == last_step) begin
            fd_oe   <= 1'b0;
            noe     <= 1'b0;
            fa      <= lat_addr;
            pollcnt <= 16'd0;
            phase   <= 1'b0;
            state   <= POLL;
          end else begin
            step       <= step + 3'd1;
            {fa, fd_o} <= next_word;
            state      <= SETUP;
          end
        end

        POLL: begin
          phase <= ~phase;
          if (phase) begin
            if (dq7_pass) begin
              if (erasing) begin
                noe   <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= VERIFY;
              end
            end else if (pollcnt >= 16'(POLL_MAX - 1)) begin
              pollcnt <= 16'(POLL_MAX);
              noe     <= 1'b1;
              error   <= 1'b1;
              state   <= ERR;
            end else begin
              pollcnt <= pollcnt + 16'd1;
            end
          end
        end

        VERIFY: begin
          phase <= ~phase;
          if (phase) begin
            noe <= 1'b1;
            if (fd_i == lat_data) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              error <= 1'b1;
              state <= ERR;
            end
          end
        end

        DONE, ERR: begin
          busy  <= 1'b0;
          nhalt <= 1'b1;
          noe   <= 1'b1;
          nwe   <= 1'b1;
          fd_oe <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_loader.sv
// Testbench for microcode_loader: a flash bus monitor checks every write against a
// queue of expected writes, and each operation's outcome against an outcome queue.
module tb_microcode_loader;

  localparam int WE_LOW   = 3;
  localparam int POLL_MAX = 1000;

  logic        clk;
  logic        reset;
  logic        req;
  logic [18:0] addr;
  logic [23:0] data;
  logic        ack, busy, done, error, nhalt;
  logic [18:0] fa;
  logic [23:0] fd_o;
  logic        fd_oe;
  logic [23:0] fd_i;
  logic        nwe, noe;
`ifdef MICROCODE_LOADER_ERASE_EN
  logic        erase;
`endif

  logic [23:0] flash_val;
  logic [18:0] poll_addr;
  int          checks = 0;
  int          passed = 0;
  int          viol = 0;
  int          writes_seen = 0;
  int          noe_low_cycles = 0;
  bit          abort_write = 0;
  logic [42:0] exp_writes[$];
  logic [1:0]  exp_outcome[$];

  microcode_loader #(.WE_LOW(WE_LOW), .POLL_MAX(POLL_MAX)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef MICROCODE_LOADER_ERASE_EN
    .erase (erase),
`endif
    .req   (req),
    .addr  (addr),
    .data  (data),
    .ack   (ack),
    .busy  (busy),
    .done  (done),
    .error (error),
    .nhalt (nhalt),
    .fa    (fa),
    .fd_o  (fd_o),
    .fd_oe (fd_oe),
    .fd_i  (fd_i),
    .nwe   (nwe),
    .noe   (noe)
  );

  // Flash model: returns the configured read value whenever output enable is asserted.
  assign fd_i = noe ? 24'h000000 : flash_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic monitor();
    logic        prev_nwe;
    logic [18:0] wfa;
    logic [23:0] wfd;
    logic [42:0] exp;
    int          lowcnt;
    prev_nwe = 1'b1;
    wfa = 19'h0;
    wfd = 24'h0;
    lowcnt = 0;
    forever begin
      @(negedge clk);
      if (nhalt === busy) viol++;
      if (!noe) begin
        noe_low_cycles++;
        if (!nwe || fd_oe || fa !== poll_addr) viol++;
      end
      if (prev_nwe && !nwe) begin
        wfa = fa;
        wfd = fd_o;
        lowcnt = 1;
        writes_seen++;
        if (!fd_oe) viol++;
        checks++;
        if (exp_writes.size() == 0) begin
          $display("[TB] FAIL write_unexpected: got fa=%h fd=%h, none expected", fa, fd_o);
        end else begin
          exp = exp_writes.pop_front();
          if ({wfa, wfd} !== exp)
            $display("[TB] FAIL write_word: got fa=%h fd=%h want fa=%h fd=%h",
                     wfa, wfd, exp[42:24], exp[23:0]);
          else
            passed++;
        end
      end else if (!prev_nwe && !nwe) begin
        lowcnt++;
        if (fa !== wfa || fd_o !== wfd || !fd_oe) viol++;
      end else if (!prev_nwe && nwe) begin
        if (abort_write) begin
          abort_write = 0;
        end else begin
          if (fa !== wfa || fd_o !== wfd || !fd_oe) viol++;
          checks++;
          if (lowcnt != WE_LOW)
            $display("[TB] FAIL we_low_width: got %0d want %0d", lowcnt, WE_LOW);
          else
            passed++;
        end
      end
      prev_nwe = nwe;
    end
  endtask

  task automatic push_program(input logic [18:0] a, input logic [23:0] d);
    exp_writes.push_back({19'h00555, 24'hAAAAAA});
    exp_writes.push_back({19'h002AA, 24'h555555});
    exp_writes.push_back({19'h00555, 24'hA0A0A0});
    exp_writes.push_back({a, d});
  endtask

  task automatic wait_idle(input int budget, output bit to, output int dcnt, output int acnt);
    to = 1;
    dcnt = 0;
    acnt = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (ack) acnt++;
      if (!busy) begin
        to = 0;
        break;
      end
    end
    if (to) begin
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      exp_writes.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 1'b1;
    addr = 19'h11111;
    data = 24'h222222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, busy, done, error, nhalt, fd_oe, nwe, noe, fa, fd_o} !==
        {8'b00001011, 19'h0, 24'h0})
      $display("[TB] FAIL reset_values: got ack=%b busy=%b done=%b error=%b nhalt=%b fd_oe=%b nwe=%b noe=%b fa=%h fd=%h",
               ack, busy, done, error, nhalt, fd_oe, nwe, noe, fa, fd_o);
    else
      passed++;
    req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, busy, nhalt} !== 3'b001)
      $display("[TB] FAIL idle_after_reset: got ack=%b busy=%b nhalt=%b want 0 0 1", ack, busy, nhalt);
    else
      passed++;
  endtask

  task automatic test_program(input string name, input logic [18:0] a, input logic [23:0] d,
                              input logic [23:0] fv, input logic [1:0] want_out,
                              input int want_noe, input int budget);
    bit         to;
    int         dcnt, acnt;
    logic [1:0] want, got;
    push_program(a, d);
    exp_outcome.push_back(want_out);
    flash_val = fv;
    poll_addr = a;
    writes_seen = 0;
    noe_low_cycles = 0;
    @(posedge clk);
    #1 addr = a; data = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0; addr = 19'h0; data = 24'h0;
    @(negedge clk);
    checks++;
    if ({ack, busy, nhalt, error, fd_oe, nwe, noe, fa, fd_o} !== {7'b1100111, 19'h00555, 24'hAAAAAA})
      $display("[TB] FAIL %s_accept: got ack=%b busy=%b nhalt=%b error=%b fd_oe=%b nwe=%b noe=%b fa=%h fd=%h",
               name, ack, busy, nhalt, error, fd_oe, nwe, noe, fa, fd_o);
    else
      passed++;
    wait_idle(budget, to, dcnt, acnt);
    checks++;
    if (to) $display("[TB] FAIL %s_timeout: busy still high after %0d cycles", name, budget);
    else passed++;
    checks++;
    if (acnt != 0) $display("[TB] FAIL %s_extra_ack: got %0d want 0", name, acnt);
    else passed++;
    want = exp_outcome.pop_front();
    got = {(dcnt == 1), error};
    checks++;
    if (got !== want) $display("[TB] FAIL %s_outcome: got done1=%b error=%b want %b %b", name, got[1], got[0], want[1], want[0]);
    else passed++;
    checks++;
    if ({busy, nhalt, noe, nwe, fd_oe, done, ack} !== 7'b0111000)
      $display("[TB] FAIL %s_idle: got busy=%b nhalt=%b noe=%b nwe=%b fd_oe=%b done=%b ack=%b",
               name, busy, nhalt, noe, nwe, fd_oe, done, ack);
    else
      passed++;
    checks++;
    if (writes_seen != 4 || exp_writes.size() != 0)
      $display("[TB] FAIL %s_writes: got %0d writes, %0d left want 4, 0", name, writes_seen, exp_writes.size());
    else
      passed++;
    checks++;
    if (noe_low_cycles != want_noe)
      $display("[TB] FAIL %s_read_cycles: got %0d want %0d", name, noe_low_cycles, want_noe);
    else
      passed++;
  endtask

  task automatic test_reset_mid();
    bit found;
    push_program(19'h12345, 24'hA5C3F0);
    flash_val = 24'hA5C3F0;
    poll_addr = 19'h12345;
    @(posedge clk);
    #1 addr = 19'h12345; data = 24'hA5C3F0; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!nwe && fd_o === 24'hA0A0A0) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) $display("[TB] FAIL reset_mid_reach_step2: got no step-2 write within 100 cycles");
    else passed++;
    abort_write = 1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({nwe, busy, nhalt, fd_oe, noe, ack, done, error, fa, fd_o} !== {8'b10101000, 19'h0, 24'h0})
      $display("[TB] FAIL reset_mid_abort: got nwe=%b busy=%b nhalt=%b fd_oe=%b noe=%b ack=%b done=%b error=%b fa=%h fd=%h",
               nwe, busy, nhalt, fd_oe, noe, ack, done, error, fa, fd_o);
    else
      passed++;
    reset = 1'b0;
    exp_writes.delete();
    test_program("after_reset", 19'h00ABC, 24'h808080, 24'h808080, 2'b10, 4, 200);
  endtask

  task automatic test_back_to_back();
    bit         to;
    int         dcnt, acnt;
    logic [1:0] want, got;
    push_program(19'h3C3C3, 24'h0F0F0F);
    push_program(19'h3C3C3, 24'h0F0F0F);
    exp_outcome.push_back(2'b10);
    exp_outcome.push_back(2'b10);
    flash_val = 24'h0F0F0F;
    poll_addr = 19'h3C3C3;
    @(posedge clk);
    #1 addr = 19'h3C3C3; data = 24'h0F0F0F; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) $display("[TB] FAIL b2b_first_ack: got %b want 1", ack);
    else passed++;
    wait_idle(200, to, dcnt, acnt);
    want = exp_outcome.pop_front();
    got = {(dcnt == 1), error};
    checks++;
    if (to || acnt != 0 || got !== want)
      $display("[TB] FAIL b2b_first_op: got timeout=%b acks=%0d outcome=%b want 0 0 %b", to, acnt, got, want);
    else
      passed++;
    @(negedge clk);
    checks++;
    if ({ack, busy} !== 2'b11) $display("[TB] FAIL b2b_second_ack: got ack=%b busy=%b want 1 1", ack, busy);
    else passed++;
    req = 1'b0;
    wait_idle(200, to, dcnt, acnt);
    want = exp_outcome.pop_front();
    got = {(dcnt == 1), error};
    checks++;
    if (to || got !== want || exp_writes.size() != 0)
      $display("[TB] FAIL b2b_second_op: got timeout=%b outcome=%b left=%0d want 0 %b 0", to, got, exp_writes.size(), want);
    else
      passed++;
  endtask

`ifdef MICROCODE_LOADER_ERASE_EN
  task automatic test_erase();
    bit         to;
    int         dcnt, acnt;
    logic [1:0] want, got;
    exp_writes.push_back({19'h00555, 24'hAAAAAA});
    exp_writes.push_back({19'h002AA, 24'h555555});
    exp_writes.push_back({19'h00555, 24'h808080});
    exp_writes.push_back({19'h00555, 24'hAAAAAA});
    exp_writes.push_back({19'h002AA, 24'h555555});
    exp_writes.push_back({19'h00555, 24'h101010});
    exp_outcome.push_back(2'b10);
    flash_val = 24'hFFFFFF;
    poll_addr = 19'h0;
    writes_seen = 0;
    noe_low_cycles = 0;
    @(posedge clk);
    #1 erase = 1'b1; req = 1'b1; addr = 19'h01234; data = 24'h00FF00;
    @(posedge clk);
    #1 erase = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack, busy, nhalt} !== 3'b010) $display("[TB] FAIL erase_start: got ack=%b busy=%b nhalt=%b want 0 1 0", ack, busy, nhalt);
    else passed++;
    wait_idle(400, to, dcnt, acnt);
    want = exp_outcome.pop_front();
    got = {(dcnt == 1), error};
    checks++;
    if (to || acnt != 0 || got !== want || writes_seen != 6 || noe_low_cycles != 2)
      $display("[TB] FAIL erase_op: got timeout=%b acks=%0d outcome=%b writes=%0d reads=%0d want 0 0 %b 6 2",
               to, acnt, got, writes_seen, noe_low_cycles, want);
    else
      passed++;
    push_program(19'h01234, 24'h00FF00);
    exp_outcome.push_back(2'b10);
    flash_val = 24'h00FF00;
    poll_addr = 19'h01234;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) $display("[TB] FAIL erase_then_req_ack: got %b want 1", ack);
    else passed++;
    req = 1'b0;
    wait_idle(200, to, dcnt, acnt);
    want = exp_outcome.pop_front();
    got = {(dcnt == 1), error};
    checks++;
    if (to || got !== want) $display("[TB] FAIL erase_then_req_op: got timeout=%b outcome=%b want 0 %b", to, got, want);
    else passed++;
  endtask
`endif

  task automatic test_invariants();
    checks++;
    if (viol != 0) $display("[TB] FAIL bus_invariants: got %0d violations want 0", viol);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0;
    addr = 19'h0;
    data = 24'h0;
    flash_val = 24'h0;
    poll_addr = 19'h0;
`ifdef MICROCODE_LOADER_ERASE_EN
    erase = 1'b0;
`endif
    fork
      monitor();
    join_none
    test_reset();
    test_program("program_basic", 19'h12345, 24'hA5C3F0, 24'hA5C3F0, 2'b10, 4, 200);
    test_program("program_top_zero", 19'h7FFFF, 24'h000000, 24'h000000, 2'b10, 4, 200);
    test_program("program_top_ones", 19'h7FFFF, 24'hFFFFFF, 24'hFFFFFF, 2'b10, 4, 200);
    test_program("program_low", 19'h00000, 24'h5A5A5A, 24'h5A5A5A, 2'b10, 4, 200);
    test_program("poll_timeout", 19'h12345, 24'hA5C3F0, 24'hA5C3F0 ^ 24'h808080, 2'b01, 2 * POLL_MAX, 5000);
    test_program("verify_fail", 19'h12345, 24'hA5C3F0, 24'hA5C3F1, 2'b01, 4, 200);
    test_reset_mid();
    test_back_to_back();
`ifdef MICROCODE_LOADER_ERASE_EN
    test_erase();
`endif
    test_invariants();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
